// File: rtl/horizontal_timing.sv
// Horizontal video timing generator: pixel-rate divider, pixel counter,
// and registered sync/active/tick decodes aligned with hCount.
module horizontal_timing #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int CLK_DIV  = 2
) (
  input  logic       Clk,
  input  logic       vgaRst,
  input  logic       enable,
  output logic       pixelTick,
  output logic [9:0] hCount,
  output logic       hSync,
  output logic       hActive,
  output logic       lineTick
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;

  // 11-bit decode constants so an end boundary of exactly 1024 still compares correctly
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] ACT_END    = 11'(H_ACTIVE);
  localparam logic [10:0] SYNC_START = 11'(H_ACTIVE + H_FRONT);
  localparam logic [10:0] SYNC_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [3:0]  DIV_LAST   = 4'(CLK_DIV - 1);

  logic [3:0] div_count;
  logic       advance;
  logic       wrap;
  logic [9:0] h_next;

  // Advance/wrap detection and next pixel index
  always_comb begin
    advance = enable && (div_count == DIV_LAST);
    wrap    = advance && ({1'b0, hCount} == H_LAST);
    h_next  = hCount;
    if (advance) h_next = wrap ? 10'd0 : hCount + 10'd1;
  end

  // Clock divider: counts only while enabled, holds otherwise
  always_ff @(posedge Clk) begin
    if (vgaRst)       div_count <= '0;
    else if (advance) div_count <= '0;
    else if (enable)  div_count <= div_count + 4'd1;
  end

  // Counter and outputs; decodes use h_next so they line up with hCount
  always_ff @(posedge Clk) begin
    if (vgaRst) begin
      hCount    <= '0;
      hSync     <= 1'b1;
      hActive   <= 1'b1;
      pixelTick <= 1'b0;
      lineTick  <= 1'b0;
    end else begin
      hCount    <= h_next;
      hSync     <= !(({1'b0, h_next} >= SYNC_START) && ({1'b0, h_next} < SYNC_END));
      hActive   <= ({1'b0, h_next} < ACT_END);
      pixelTick <= advance;
      lineTick  <= wrap;
    end
  end

endmodule

// File: tb/tb_horizontal_timing.sv
// Bench for horizontal_timing: default config against a cycle model and
// timing measurements, plus a small CLK_DIV=1 config against a vector table.
module tb_horizontal_timing;

  logic       Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       vgaRst, enable;
  logic       pixelTick, hSync, hActive, lineTick;
  logic [9:0] hCount;

  logic       rst2, en2;
  logic       pt2, hs2, ha2, lt2;
  logic [9:0] hc2;

  horizontal_timing u_dut (
    .Clk(Clk), .vgaRst(vgaRst), .enable(enable), .pixelTick(pixelTick),
    .hCount(hCount), .hSync(hSync), .hActive(hActive), .lineTick(lineTick)
  );

  horizontal_timing #(.H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3), .CLK_DIV(1)) u_small (
    .Clk(Clk), .vgaRst(rst2), .enable(en2), .pixelTick(pt2),
    .hCount(hc2), .hSync(hs2), .hActive(ha2), .lineTick(lt2)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [9:0] h;
    logic       hs, ha, pt, lt;
  } obs_t;

  typedef struct {
    logic       rst, en;
    logic [9:0] h;
    logic       hs, ha, pt, lt;
  } vec_t;

  function automatic vec_t mk(input logic rst, en, input int h, input logic hs, ha, pt, lt);
    vec_t v;
    v.rst = rst; v.en = en; v.h = 10'(h); v.hs = hs; v.ha = ha; v.pt = pt; v.lt = lt;
    return v;
  endfunction

  // Reference model state for the default configuration
  localparam int DIV = 2;
  localparam int TOT = 800;
  int   m_div, m_h;
  logic m_pt, m_lt;
  obs_t sbq[$];
  obs_t cur;
  int   cyc;

  task automatic step(input logic en, input logic rst);
    obs_t e, got;
    enable = en;
    vgaRst = rst;
    @(posedge Clk);
    if (rst) begin
      m_div = 0; m_h = 0; m_pt = 0; m_lt = 0;
    end else if (en) begin
      if (m_div == DIV - 1) begin
        m_pt = 1; m_lt = (m_h == TOT - 1);
        m_h = (m_h == TOT - 1) ? 0 : m_h + 1;
        m_div = 0;
      end else begin
        m_pt = 0; m_lt = 0; m_div++;
      end
    end else begin
      m_pt = 0; m_lt = 0;
    end
    e.h = 10'(m_h);
    e.hs = !(m_h >= 656 && m_h < 752);
    e.ha = (m_h < 640);
    e.pt = m_pt;
    e.lt = m_lt;
    sbq.push_back(e);
    #1;
    got = '{hCount, hSync, hActive, pixelTick, lineTick};
    e = sbq.pop_front();
    chk("scoreboard", 32'(got), 32'(e));
    cur = got;
    cyc = rst ? 0 : cyc + 1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[30];
    int first_pt, first799, lt1, lt2c, hs_low, ha_hi, hs_start_h, hs_end_h, n;
    logic prev_hs;

    tbl[0]  = mk(1,0, 0,1,1,0,0);
    tbl[1]  = mk(0,1, 1,1,1,1,0);
    tbl[2]  = mk(0,1, 2,1,1,1,0);
    tbl[3]  = mk(0,1, 3,1,1,1,0);
    tbl[4]  = mk(0,1, 4,1,1,1,0);
    tbl[5]  = mk(0,1, 5,1,1,1,0);
    tbl[6]  = mk(0,1, 6,1,1,1,0);
    tbl[7]  = mk(0,1, 7,1,1,1,0);
    tbl[8]  = mk(0,1, 8,1,0,1,0);
    tbl[9]  = mk(0,1, 9,1,0,1,0);
    tbl[10] = mk(0,1,10,0,0,1,0);
    tbl[11] = mk(0,1,11,0,0,1,0);
    tbl[12] = mk(0,1,12,0,0,1,0);
    tbl[13] = mk(0,1,13,1,0,1,0);
    tbl[14] = mk(0,1,14,1,0,1,0);
    tbl[15] = mk(0,1,15,1,0,1,0);
    tbl[16] = mk(0,1, 0,1,1,1,1);
    tbl[17] = mk(0,1, 1,1,1,1,0);
    tbl[18] = mk(0,0, 1,1,1,0,0);
    tbl[19] = mk(0,1, 2,1,1,1,0);
    tbl[20] = mk(0,1, 3,1,1,1,0);
    tbl[21] = mk(0,1, 4,1,1,1,0);
    tbl[22] = mk(0,1, 5,1,1,1,0);
    tbl[23] = mk(0,1, 6,1,1,1,0);
    tbl[24] = mk(0,1, 7,1,1,1,0);
    tbl[25] = mk(0,1, 8,1,0,1,0);
    tbl[26] = mk(0,1, 9,1,0,1,0);
    tbl[27] = mk(0,1,10,0,0,1,0);
    tbl[28] = mk(1,1, 0,1,1,0,0);
    tbl[29] = mk(0,1, 1,1,1,1,0);

    vgaRst = 1'b1; enable = 1'b0; rst2 = 1'b1; en2 = 1'b0;
    cyc = 0; m_div = 0; m_h = 0; m_pt = 0; m_lt = 0;

    // Small configuration: table of vectors
    for (int i = 0; i < 30; i++) begin
      rst2 = tbl[i].rst;
      en2  = tbl[i].en;
      @(posedge Clk);
      #1;
      chk($sformatf("vec%0d", i), {18'd0, hc2, hs2, ha2, pt2, lt2},
          {18'd0, tbl[i].h, tbl[i].hs, tbl[i].ha, tbl[i].pt, tbl[i].lt});
    end

    // Default configuration: reset state (enable high during reset)
    step(1, 1);
    chk("rst_hcount", hCount, 0);
    chk("rst_hsync", hSync, 1);
    chk("rst_hactive", hActive, 1);
    chk("rst_ticks", {pixelTick, lineTick}, 0);

    // Two full lines from reset
    first_pt = -1; first799 = -1; lt1 = -1; lt2c = -1;
    hs_low = 0; ha_hi = 0; hs_start_h = -1; hs_end_h = -1; prev_hs = 1'b1;
    for (int i = 0; i < 3200; i++) begin
      step(1, 0);
      if (cur.pt && first_pt < 0) first_pt = cyc;
      if (cur.h == 10'd799 && first799 < 0) first799 = cyc;
      if (cur.lt) begin
        if (lt1 < 0) lt1 = cyc; else lt2c = cyc;
      end
      if (cyc > 1600) begin
        if (!cur.hs) hs_low++;
        if (cur.ha) ha_hi++;
        if (prev_hs && !cur.hs && hs_start_h < 0) hs_start_h = int'(cur.h);
        if (!prev_hs && cur.hs && hs_end_h < 0) hs_end_h = int'(cur.h);
      end
      prev_hs = cur.hs;
    end
    chk("first_pixeltick_cyc", first_pt, 2);
    chk("hcount799_cyc", first799, 1598);
    chk("first_linetick_cyc", lt1, 1600);
    chk("line_period", lt2c - lt1, 1600);
    chk("hsync_low_clks", hs_low, 192);
    chk("hactive_clks", ha_hi, 1280);
    chk("hsync_start_h", hs_start_h, 656);
    chk("hsync_end_h", hs_end_h, 752);

    // Enable pause of 7 clocks at hCount=300, mid-divider
    n = 0;
    while (!(cur.h == 10'd300 && !cur.pt) && n < 2000) begin step(1, 0); n++; end
    chk("reach_h300", n < 2000, 1);
    for (int i = 0; i < 7; i++) begin
      step(0, 0);
      if (cur.h != 10'd300 || cur.pt || cur.lt) chk("pause_frozen", {cur.h, cur.pt, cur.lt}, {10'd300, 2'b00});
    end
    chk("pause_h", cur.h, 300);
    n = 0;
    while (!cur.lt && n < 2000) begin step(1, 0); n++; end
    chk("stretched_period", cyc - lt2c, 1607);

    // Reset mid sync pulse
    n = 0;
    while (cur.h != 10'd700 && n < 2000) begin step(1, 0); n++; end
    chk("h700_hsync", cur.hs, 0);
    step(1, 1);
    chk("midrst_state", {cur.h, cur.hs, cur.ha, cur.lt}, {10'd0, 3'b110});
    step(1, 0);
    chk("post_rst_pt1", cur.pt, 0);
    step(1, 0);
    chk("post_rst_pt2", {cur.pt, cur.h}, {1'b1, 10'd1});

    // Reset on the wrap cycle must suppress lineTick
    n = 0;
    while (!(cur.h == 10'd799 && !cur.pt) && n < 2000) begin step(1, 0); n++; end
    chk("reach_h799", n < 2000, 1);
    step(1, 1);
    chk("wrap_rst", {cur.h, cur.lt, cur.hs}, {10'd0, 2'b01});
    step(1, 0);
    chk("wrap_rst_after", {cur.h, cur.lt, cur.pt}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/horizontal_timing.md
HORIZONTAL_TIMING -- requirements
Module: horizontal_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 16, front-porch pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96, sync-pulse pixels.
REQ-004 The block SHALL have parameter H_BACK, default 48, back-porch pixels; H_TOTAL = sum of the four parameters (default 800).
REQ-005 The block SHALL have parameter CLK_DIV, default 2, Clk cycles per pixel, legal range 1..16.
REQ-006 The block SHALL have port Clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-007 The block SHALL have port vgaRst, input, 1; reset is synchronous and active-high.
REQ-008 The block SHALL have port enable, input, 1, timing advances only while high.
REQ-009 The block SHALL have port pixelTick, output, 1, one-Clk pulse marking each pixel advance.
REQ-010 The block SHALL have port hCount, output, 10, current pixel index 0..H_TOTAL-1.
REQ-011 The block SHALL have port hSync, output, 1, horizontal sync, active-low.
REQ-012 The block SHALL have port hActive, output, 1, high while hCount < H_ACTIVE.
REQ-013 The block SHALL have port lineTick, output, 1, one-Clk pulse per completed line; it is the line-rate advance for the downstream vertical counter.

Function
REQ-014 An internal divider divCount SHALL count 0..CLK_DIV-1 while enable is high, wrap to 0 and hold its value while enable is low.
REQ-015 The advance condition SHALL be: enable high and divCount == CLK_DIV-1; with CLK_DIV = 1, advance equals enable.
REQ-016 On an advance edge, hCount SHALL increment by 1, or wrap from H_TOTAL-1 to 0; otherwise it holds.
REQ-017 pixelTick SHALL be registered, high for exactly the one Clk cycle following each advance edge, low otherwise.
REQ-018 hSync and hActive SHALL be registered and decoded from the next value of hCount, so they are consistent with hCount in every cycle (zero relative skew).
REQ-019 hSync SHALL be 0 iff H_ACTIVE+H_FRONT <= hCount < H_ACTIVE+H_FRONT+H_SYNC (default 656..751), else 1.
REQ-020 lineTick SHALL be high for exactly the one Clk cycle in which hCount first reads 0 after a wrap from H_TOTAL-1; no pulse is produced on release from reset.
REQ-021 With enable held low, all outputs SHALL hold, and pixelTick and lineTick SHALL be 0.
REQ-022 Deasserting enable on the cycle of an advance SHALL NOT cancel the advance already registered; the next advance occurs after the remaining divider cycles once enable returns.
REQ-023 hCount arithmetic SHALL be 10-bit unsigned and never exceed H_TOTAL-1; H_TOTAL > 1024 is illegal.

Reset
REQ-024 When vgaRst is high at a Clk edge, the next state SHALL be: divCount=0, hCount=0, hSync=1, hActive=1, pixelTick=0, lineTick=0, regardless of enable.
REQ-025 Reset asserted mid-line, including during the sync pulse or on a wrap cycle, SHALL abort the line with no lineTick and no residual hSync low.
REQ-026 The first advance after reset release SHALL occur CLK_DIV enabled cycles later.

Verification
REQ-027 Defaults, enable=1 from reset: pixelTick every 2 Clk; hCount reaches 799 after 1598 Clk, then 0 with lineTick=1 for 1 Clk; lineTick period exactly 1600 Clk.
REQ-028 Defaults: hSync=0 for exactly 192 Clk per line, starting when hCount=656 and ending when hCount=752; hActive=1 for 1280 Clk per line (hCount 0..639).
REQ-029 Toggle enable low for 7 Clk at hCount=300, mid-divider: hCount, hSync, hActive frozen; pixelTick=0; line period stretches to exactly 1607 Clk.
REQ-030 Assert vgaRst for 1 Clk at hCount=700 (hSync=0): next cycle hCount=0, hSync=1, hActive=1, lineTick=0; first pixelTick 2 Clk after release.
REQ-031 CLK_DIV=1, H_ACTIVE=8, H_FRONT=2, H_SYNC=3, H_BACK=3: pixelTick constantly high, hCount cycles 0..15, hSync low at 10..12, lineTick period 16 Clk.
